// File: rtl/bf16_minmax_reduce_if.sv
// Handshake bundle between the BF16 min/max reduction engine and its environment.
// master: the reduction engine. slave: the job source / operand producer / result consumer.
interface bf16_minmax_reduce_if #(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned IDX_W   = $clog2(MAX_LEN)
);
    logic              start;
    logic [IDX_W:0]    len;
    logic              operation;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;
    logic [IDX_W-1:0]  out_index;
    logic              out_all_nan;
    logic              busy;

    modport master (
        input  start, len, operation, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_result, out_index, out_all_nan, busy
    );

    modport slave (
        output start, len, operation, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_result, out_index, out_all_nan, busy
    );
endinterface

// File: rtl/bf16_minmax_reduce.sv
// Streaming BF16 min/max reduction: one operand per cycle into a running
// accumulator, single result handed out over valid/ready.
// NaN operands never win; an all-NaN or empty job returns canonical NaN 0x7FC0.
// Optional feature macro: BF16_REDUCE_ARGIDX_EN builds index tracking for out_index;
// when undefined out_index is tied to 0.
module bf16_minmax_reduce #(
    parameter int unsigned MAX_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bf16_minmax_reduce_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(MAX_LEN);
    localparam int unsigned LEN_W = IDX_W + 1;
    localparam logic [15:0] CANON_NAN = 16'h7FC0;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              op_q, op_d;
    logic [15:0]       acc_q, acc_d;
    logic              acc_empty_q, acc_empty_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_result_q, out_result_d;
    logic              out_all_nan_q, out_all_nan_d;
    logic              busy_q, busy_d;
`ifdef BF16_REDUCE_ARGIDX_EN
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
`endif

    logic              accept;
    logic              new_is_nan;
    logic [15:0]       key_new;
    logic [15:0]       key_acc;
    logic              better;
    logic              replace;
    logic              last;

    // Monotonic unsigned key: negatives inverted, positives offset above them.
    function automatic logic [15:0] order_key(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    // Operand classification and compare against the running accumulator.
    assign accept     = (state_q == ACCUM) && bus.in_valid && in_ready_q;
    assign new_is_nan = (bus.in_data[14:7] == 8'hFF) && (bus.in_data[6:0] != 7'd0);
    assign key_new    = order_key(bus.in_data);
    assign key_acc    = order_key(acc_q);
    assign better     = op_q ? (key_new > key_acc) : (key_new < key_acc);
    assign replace    = !new_is_nan && (acc_empty_q || better);
    assign last       = (count_q == (len_q - LEN_W'(1)));

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        op_d          = op_q;
        acc_d         = acc_q;
        acc_empty_d   = acc_empty_q;
        out_result_d  = out_result_q;
        out_all_nan_d = out_all_nan_q;
`ifdef BF16_REDUCE_ARGIDX_EN
        idx_d         = idx_q;
        out_index_d   = out_index_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == LEN_W'(0)) begin
                        state_d       = DONE;
                        out_result_d  = CANON_NAN;
                        out_all_nan_d = 1'b1;
`ifdef BF16_REDUCE_ARGIDX_EN
                        out_index_d   = '0;
`endif
                    end else begin
                        state_d     = ACCUM;
                        len_d       = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
                        op_d        = bus.operation;
                        count_d     = '0;
                        acc_empty_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (replace) begin
                        acc_d       = bus.in_data;
                        acc_empty_d = 1'b0;
`ifdef BF16_REDUCE_ARGIDX_EN
                        idx_d       = count_q[IDX_W-1:0];
`endif
                    end
                    count_d = count_q + LEN_W'(1);
                    if (last) begin
                        state_d = DONE;
                        if (acc_empty_d) begin
                            out_result_d  = CANON_NAN;
                            out_all_nan_d = 1'b1;
`ifdef BF16_REDUCE_ARGIDX_EN
                            out_index_d   = '0;
`endif
                        end else begin
                            out_result_d  = acc_d;
                            out_all_nan_d = 1'b0;
`ifdef BF16_REDUCE_ARGIDX_EN
                            out_index_d   = idx_d;
`endif
                        end
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            op_q          <= 1'b0;
            acc_q         <= '0;
            acc_empty_q   <= 1'b1;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_all_nan_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef BF16_REDUCE_ARGIDX_EN
            idx_q         <= '0;
            out_index_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            op_q          <= op_d;
            acc_q         <= acc_d;
            acc_empty_q   <= acc_empty_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_all_nan_q <= out_all_nan_d;
            busy_q        <= busy_d;
`ifdef BF16_REDUCE_ARGIDX_EN
            idx_q         <= idx_d;
            out_index_q   <= out_index_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_all_nan = out_all_nan_q;
    assign bus.busy        = busy_q;
`ifdef BF16_REDUCE_ARGIDX_EN
    assign bus.out_index   = out_index_q;
`else
    assign bus.out_index   = '0;
`endif

endmodule

// File: tb/tb_bf16_minmax_reduce.sv
// Directed bench for bf16_minmax_reduce: vector table plus reset / handshake sequences.
module tb_bf16_minmax_reduce;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned IDX_W   = 8;

    typedef struct {
        logic            op;
        int              len;
        logic [3:0][15:0] d;
        logic [15:0]     res;
        int              idx;
        logic            nan;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[12];

    bf16_minmax_reduce_if #(.MAX_LEN(MAX_LEN)) bus ();

    bf16_minmax_reduce #(.MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic op, input int len,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input logic [15:0] res, input int idx, input logic nan);
        vec_t v;
        v.op = op; v.len = len;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.res = res; v.idx = idx; v.nan = nan;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input bit gaps, input int hold, input bit pulse);
        int i;
        int guard;
        logic rdy;
        logic [IDX_W-1:0] eidx;
`ifdef BF16_REDUCE_ARGIDX_EN
        eidx = IDX_W'(v.idx);
`else
        eidx = '0;
`endif
        @(negedge clk);
        bus.start     = 1'b1;
        bus.len       = 9'(v.len);
        bus.operation = v.op;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.operation = ~v.op;
        if (v.len == 0) chk("len0_latency", 32'(bus.out_valid), 32'd1);
        else            chk("accum_ready", 32'(bus.in_ready), 32'd1);
        i = 0;
        guard = 0;
        while (i < v.len && guard < 100) begin
            rdy = bus.in_ready;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = v.d[i];
            end
            bus.start = pulse && (i == 1);
            @(negedge clk);
            if (bus.in_valid && rdy) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (guard >= 100) chk("accept_timeout", 32'(i), 32'(v.len));
        chk("done_valid",   32'(bus.out_valid),   32'd1);
        chk("done_ready_lo",32'(bus.in_ready),    32'd0);
        chk("done_busy",    32'(bus.busy),        32'd1);
        chk("result",       32'(bus.out_result),  32'(v.res));
        chk("index",        32'(bus.out_index),   32'(eidx));
        chk("all_nan",      32'(bus.out_all_nan), 32'(v.nan));
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid",  32'(bus.out_valid),  32'd1);
            chk("hold_result", 32'(bus.out_result), 32'(v.res));
            chk("hold_index",  32'(bus.out_index),  32'(eidx));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("consumed_valid", 32'(bus.out_valid), 32'd0);
        chk("consumed_busy",  32'(bus.busy),      32'd0);
        @(negedge clk);
        chk("single_xfer", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = mk(1'b1, 4, 16'h3F80, 16'hC040, 16'h4000, 16'h3F00, 16'h4000, 2, 1'b0);
        vecs[1]  = mk(1'b0, 4, 16'h3F80, 16'hC040, 16'h4000, 16'h3F00, 16'hC040, 1, 1'b0);
        vecs[2]  = mk(1'b0, 3, 16'h7FC1, 16'h3F00, 16'h7F81, 16'h0000, 16'h3F00, 1, 1'b0);
        vecs[3]  = mk(1'b0, 2, 16'h7FC1, 16'hFFC0, 16'h0000, 16'h0000, 16'h7FC0, 0, 1'b1);
        vecs[4]  = mk(1'b1, 2, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0);
        vecs[5]  = mk(1'b0, 2, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 0, 1'b0);
        vecs[6]  = mk(1'b1, 2, 16'h3F80, 16'h3F80, 16'h0000, 16'h0000, 16'h3F80, 0, 1'b0);
        vecs[7]  = mk(1'b1, 3, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0000, 16'h7F80, 0, 1'b0);
        vecs[8]  = mk(1'b0, 3, 16'h0001, 16'h8001, 16'h0000, 16'h0000, 16'h8001, 1, 1'b0);
        vecs[9]  = mk(1'b0, 3, 16'h3F80, 16'h3F80, 16'h3F00, 16'h0000, 16'h3F00, 2, 1'b0);
        vecs[10] = mk(1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FC0, 0, 1'b1);
        vecs[11] = mk(1'b1, 1, 16'hFFC0, 16'h0000, 16'h0000, 16'h0000, 16'h7FC0, 0, 1'b1);

        bus.start = 1'b0; bus.len = '0; bus.operation = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),    32'd0);
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_result",    32'(bus.out_result),  32'd0);
        chk("rst_index",     32'(bus.out_index),   32'd0);
        chk("rst_all_nan",   32'(bus.out_all_nan), 32'd0);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) run_job(vecs[k], 1'b0, 0, 1'b0);

        // In_valid gaps and a stalled consumer.
        run_job(vecs[0], 1'b1, 5, 1'b0);
        // Start pulsed mid-job must be ignored.
        run_job(mk(1'b1, 3, 16'h3F00, 16'h4040, 16'h3F80, 16'h0000, 16'h4040, 1, 1'b0),
                1'b0, 0, 1'b1);

        // Reset after 2 of 4 elements, then a fresh single-element job.
        @(negedge clk);
        bus.start = 1'b1; bus.len = 9'd4; bus.operation = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h3F80;
        @(negedge clk);
        bus.in_data = 16'h4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(bus.in_ready),    32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("midrst_result",    32'(bus.out_result),  32'd0);
        chk("midrst_index",     32'(bus.out_index),   32'd0);
        chk("midrst_all_nan",   32'(bus.out_all_nan), 32'd0);
        chk("midrst_busy",      32'(bus.busy),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(mk(1'b0, 1, 16'hC040, 16'h0000, 16'h0000, 16'h0000, 16'hC040, 0, 1'b0),
                1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
